// File: rtl/pipe_stage_buf_pkg.sv
// Shared types for the if_id pipeline buffer: state encoding, stage payload
// struct and the bubble (all-control-clear) payload.
package Pipe_Buf_Reg_PKG;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  // if_id stage payload; the bubble has every field cleared.
  typedef struct packed {
    logic        valid;
    logic [7:0]  ctrl;
    logic [31:0] pc;
  } if_id_t;

  localparam int IF_ID_W = $bits(if_id_t);

  localparam logic [IF_ID_W-1:0] BUBBLE_IF_ID = {IF_ID_W{1'b0}};

  function automatic logic [1:0] state_occupancy(input buf_state_e st);
    logic [1:0] occ;
    case (st)
      ST_EMPTY: occ = 2'd0;
      ST_ONE:   occ = 2'd1;
      ST_FULL:  occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready handshake bundle between two pipeline stages and the buffer.
interface pipe_stage_buf_if #(
  parameter int WIDTH = 41
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // Buffer side.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  // Environment side: drives upstream payload and downstream ready.
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

endinterface

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating event counter used to measure downstream stall cycles.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry skid buffer between pipeline stages with flush, occupancy and a
// saturating stall counter. All handshake outputs come straight from flops.
module pipe_stage_buf
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int WIDTH = 41,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_stage_buf_if.slave  bus,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [WIDTH-1:0] BUBBLE = WIDTH'(BUBBLE_IF_ID);

  buf_state_e       state_q;
  buf_state_e       state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [1:0]       occ_q;
  logic             accept_s;
  logic             drain_s;
  logic             stall_s;

  assign accept_s = bus.in_valid & in_ready_q;
  assign drain_s  = out_valid_q & bus.out_ready;
  assign stall_s  = out_valid_q & ~bus.out_ready;

  // Next-state and datapath selection; emptied slots are refilled with the
  // bubble so out_data is zero whenever out_valid is low.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            state_d = ST_ONE;
            main_d  = bus.in_data;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && drain_s) begin
            state_d = ST_ONE;
            main_d  = bus.in_data;
          end else if (accept_s) begin
            state_d = ST_FULL;
            skid_d  = bus.in_data;
          end else if (drain_s) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          if (drain_s) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
  end

  // State, payload and handshake output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_q      <= BUBBLE;
      skid_q      <= BUBBLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != ST_FULL);
      out_valid_q <= (state_d != ST_EMPTY);
      occ_q       <= state_occupancy(state_d);
    end
  end

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear_i (1'b0),
    .inc_i   (stall_s),
    .cnt_o   (stall_cnt)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;
  assign occupancy     = occ_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf.
module tb_pipe_stage_buf;
  import Pipe_Buf_Reg_PKG::*;

  localparam int W  = IF_ID_W;
  localparam int CW = 16;

  logic          clk;
  logic          reset;
  logic          flush;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;

  int n_cmp;
  int n_err;

  pipe_stage_buf_if #(.WIDTH(W)) bus ();

  pipe_stage_buf #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".in_ready"},  64'(bus.in_ready),  64'd1);
    check({tag, ".out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, ".out_data"},  64'(bus.out_data),  64'd0);
    check({tag, ".occ"},       64'(occupancy),     64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #2;

    // Reset state
    do_reset();
    check_idle("rst");
    check("rst.stall", 64'(stall_cnt), 64'd0);

    // Single accept from EMPTY: one-cycle latency
    bus.in_valid = 1'b1; bus.in_data = W'(12'h0AA); bus.out_ready = 1'b1;
    tick();
    check("lat.out_valid", 64'(bus.out_valid), 64'd1);
    check("lat.out_data",  64'(bus.out_data),  64'h0AA);
    check("lat.occ",       64'(occupancy),     64'd1);
    bus.in_valid = 1'b0;
    tick();
    check_idle("lat.drained");

    // Stall fill to FULL, then drain in order
    do_reset();
    bus.in_valid = 1'b1; bus.in_data = W'(4'h1); bus.out_ready = 1'b0;
    tick();
    check("ord.d1", 64'(bus.out_data), 64'h1);
    check("ord.occ1", 64'(occupancy), 64'd1);
    bus.in_data = W'(4'h2);
    tick();
    check("ord.in_ready_full", 64'(bus.in_ready), 64'd0);
    check("ord.occ2", 64'(occupancy), 64'd2);
    check("ord.head", 64'(bus.out_data), 64'h1);
    check("ord.stall1", 64'(stall_cnt), 64'd1);
    bus.in_data = W'(4'h3); bus.out_ready = 1'b1;
    tick();
    check("ord.d2", 64'(bus.out_data), 64'h2);
    check("ord.occ_back1", 64'(occupancy), 64'd1);
    check("ord.in_ready_back", 64'(bus.in_ready), 64'd1);
    tick();
    check("ord.d3", 64'(bus.out_data), 64'h3);
    check("ord.stall_hold", 64'(stall_cnt), 64'd1);
    bus.in_valid = 1'b0;
    tick();
    check_idle("ord.empty");

    // Flush in FULL with a same-cycle offer
    do_reset();
    bus.in_valid = 1'b1; bus.in_data = W'(8'h11); bus.out_ready = 1'b0;
    tick();
    bus.in_data = W'(8'h22);
    tick();
    check("fl.occ_full", 64'(occupancy), 64'd2);
    flush = 1'b1; bus.in_data = W'(4'h5);
    tick();
    check_idle("fl.after");
    check("fl.stall", 64'(stall_cnt), 64'd2);
    flush = 1'b0; bus.in_valid = 1'b0;
    tick();
    check_idle("fl.no5");

    // Back-to-back streaming, one transfer per cycle
    do_reset();
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_data = W'(64'h100 + 64'(i));
      tick();
      check($sformatf("str.v%0d", i), 64'(bus.out_valid), 64'd1);
      check($sformatf("str.d%0d", i), 64'(bus.out_data), 64'h100 + 64'(i));
      check($sformatf("str.rdy%0d", i), 64'(bus.in_ready), 64'd1);
    end
    bus.in_valid = 1'b0;
    tick();
    check_idle("str.end");

    // Stall counter saturation and reset
    do_reset();
    bus.in_valid = 1'b1; bus.in_data = W'(4'h7); bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    check("sat.max", 64'(stall_cnt), 64'd65535);
    tick();
    check("sat.hold", 64'(stall_cnt), 64'd65535);
    check("sat.valid", 64'(bus.out_valid), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("sat.rst", 64'(stall_cnt), 64'd0);

    // Reset overrides flush and handshakes in FULL
    do_reset();
    bus.in_valid = 1'b1; bus.in_data = W'(8'h33); bus.out_ready = 1'b0;
    tick();
    bus.in_data = W'(8'h44);
    tick();
    check("rf.occ_full", 64'(occupancy), 64'd2);
    reset = 1'b1; flush = 1'b1; bus.in_data = W'(8'h55); bus.out_ready = 1'b1;
    tick();
    check_idle("rf.after");
    check("rf.stall", 64'(stall_cnt), 64'd0);
    reset = 1'b0; flush = 1'b0; bus.in_valid = 1'b0;
    tick();
    check_idle("rf.dropped");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
